// File: rtl/sensor_pause_pkg.sv
// Shared types and constants for the sensor-triggered drivetrain pause controller.
package sensor_pause_pkg;

  // Pause sequencer states: idle, motors held off, motors back on with pause flag set.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALT  = 2'd1,
    CREEP = 2'd2
  } state_t;

  // Default durations: 1.5 s total pause, 0.75 s motor-off phase at 50 MHz.
  localparam int unsigned DEF_CNT_W     = 27;
  localparam int unsigned DEF_PAUSE_CYC = 75_000_000;
  localparam int unsigned DEF_HALF_CYC  = 37_500_000;

  // True when value is representable in an unsigned counter of the given width.
  function automatic bit fits_width(input longint unsigned value, input int unsigned width);
    if (width >= 64) return 1'b1;
    return (value >> width) == 0;
  endfunction

endpackage

// File: rtl/sns_trigger.sv
// Sensor front-end: optional synchroniser chain, edge register, mask and
// edge/level qualification producing one trigger bit per channel.
module sns_trigger #(
  parameter int unsigned N_SNS       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_MODE   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SNS-1:0] sns,
  input  logic [N_SNS-1:0] mask,
  output logic [N_SNS-1:0] trig
);

  logic [N_SNS-1:0] sync;
  logic [N_SNS-1:0] sync_d;

  if (SYNC_STAGES == 0) begin : g_no_sync
    assign sync = sns;
  end else begin : g_sync
    logic [N_SNS-1:0] stage_q [SYNC_STAGES];

    // Shift raw requests through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: the chain is reset so no phantom rising edge appears after reset release.
        for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      end else begin
        // NOTE: non-blocking so each stage captures its predecessor's previous value.
        stage_q[0] <= sns;
        for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign sync = stage_q[SYNC_STAGES-1];
  end

  // Remember last synchronised value for rising-edge detection; an input
  // already high at reset release therefore counts as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_d <= '0;
    else        sync_d <= sync;
  end

  assign trig = ~mask & (EDGE_MODE ? (sync & ~sync_d) : sync);

endmodule

// File: rtl/sensor_pause_ctrl.sv
// Two-phase drivetrain pause: any qualified sensor trigger disables the motors
// for HALF_CYC cycles, then re-enables them while Pause stays high until
// PAUSE_CYC cycles have elapsed. Reports the triggering channels and a Done pulse.
module sensor_pause_ctrl
  import sensor_pause_pkg::*;
#(
  parameter int unsigned N_SNS       = 2,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned PAUSE_CYC   = DEF_PAUSE_CYC,
  parameter int unsigned HALF_CYC    = DEF_HALF_CYC,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_MODE   = 1'b1,
  parameter bit          RETRIG      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SNS-1:0] SnsDisable,
  input  logic [N_SNS-1:0] SnsMask,
  input  logic             ForceClear,
  output logic             Enable,
  output logic             Pause,
  output logic [N_SNS-1:0] Cause,
  output logic             Done
);

  if (N_SNS < 1 || N_SNS > 16) begin : g_bad_n_sns
    $error("N_SNS must be in 1..16");
  end
  if (HALF_CYC < 1 || HALF_CYC >= PAUSE_CYC) begin : g_bad_half
    $error("HALF_CYC must satisfy 1 <= HALF_CYC < PAUSE_CYC");
  end
  if (!fits_width(longint'(PAUSE_CYC), CNT_W)) begin : g_bad_width
    $error("PAUSE_CYC does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [N_SNS-1:0] trig;
  logic             any_trig;
  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             enable_q;
  logic             pause_q;
  logic [N_SNS-1:0] cause_q;
  logic             done_q;

  sns_trigger #(
    .N_SNS      (N_SNS),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_MODE  (EDGE_MODE)
  ) u_trigger (
    .clk  (clk),
    .rst_n(rst_n),
    .sns  (SnsDisable),
    .mask (SnsMask),
    .trig (trig)
  );

  assign any_trig = |trig;

  // Pause sequencer with phase timer and registered Enable/Pause/Cause/Done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      enable_q <= 1'b1;
      pause_q  <= 1'b0;
      cause_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ForceClear) begin
        // Abort wins over everything; Cause is kept for diagnosis.
        state    <= IDLE;
        timer    <= '0;
        enable_q <= 1'b1;
        pause_q  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (any_trig) begin
              state    <= HALT;
              timer    <= '0;
              enable_q <= 1'b0;
              pause_q  <= 1'b1;
              cause_q  <= trig;
            end
          end
          HALT: begin
            cause_q <= cause_q | trig;
            if (RETRIG && any_trig) begin
              timer <= '0;
            end else begin
              timer <= timer + ONE;
              if (timer == HALF_LAST) begin
                state    <= CREEP;
                enable_q <= 1'b1;
              end
            end
          end
          CREEP: begin
            if (timer == PAUSE_LAST) begin
              // A fresh edge on the last cycle chains straight into a new pause.
              // In level mode a still-asserted request is serviced from IDLE
              // instead, so a stuck sensor yields one Pause-low cycle per period.
              if (EDGE_MODE && any_trig) begin
                state    <= HALT;
                timer    <= '0;
                enable_q <= 1'b0;
                cause_q  <= trig;
              end else begin
                state   <= IDLE;
                timer   <= '0;
                pause_q <= 1'b0;
                done_q  <= 1'b1;
              end
            end else if (RETRIG && any_trig) begin
              state    <= HALT;
              timer    <= '0;
              enable_q <= 1'b0;
              cause_q  <= cause_q | trig;
            end else begin
              timer   <= timer + ONE;
              cause_q <= cause_q | trig;
            end
          end
          default: begin
            state    <= IDLE;
            timer    <= '0;
            enable_q <= 1'b1;
            pause_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Enable = enable_q;
  assign Pause  = pause_q;
  assign Cause  = cause_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_sensor_pause_ctrl.sv
// Directed bench: four controller instances share the sensor inputs and differ
// in retrigger policy, edge/level qualification and synchroniser depth.
module tb_sensor_pause_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sns = 2'b00;
  logic [1:0] mask = 2'b00;
  logic       fc = 1'b0;

  logic en_a, pause_a, done_a; logic [1:0] cause_a;
  logic en_b, pause_b, done_b; logic [1:0] cause_b;
  logic en_c, pause_c, done_c; logic [1:0] cause_c;
  logic en_d, pause_d, done_d; logic [1:0] cause_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // a: edge mode, no retrigger, no synchroniser
  sensor_pause_ctrl #(.N_SNS(2), .CNT_W(8), .PAUSE_CYC(10), .HALF_CYC(4),
                      .SYNC_STAGES(0), .EDGE_MODE(1'b1), .RETRIG(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .SnsDisable(sns), .SnsMask(mask), .ForceClear(fc),
    .Enable(en_a), .Pause(pause_a), .Cause(cause_a), .Done(done_a));

  // b: edge mode with retrigger
  sensor_pause_ctrl #(.N_SNS(2), .CNT_W(8), .PAUSE_CYC(10), .HALF_CYC(4),
                      .SYNC_STAGES(0), .EDGE_MODE(1'b1), .RETRIG(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .SnsDisable(sns), .SnsMask(mask), .ForceClear(fc),
    .Enable(en_b), .Pause(pause_b), .Cause(cause_b), .Done(done_b));

  // c: level mode
  sensor_pause_ctrl #(.N_SNS(2), .CNT_W(8), .PAUSE_CYC(10), .HALF_CYC(4),
                      .SYNC_STAGES(0), .EDGE_MODE(1'b0), .RETRIG(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .SnsDisable(sns), .SnsMask(mask), .ForceClear(fc),
    .Enable(en_c), .Pause(pause_c), .Cause(cause_c), .Done(done_c));

  // d: two-stage synchroniser
  sensor_pause_ctrl #(.N_SNS(2), .CNT_W(8), .PAUSE_CYC(10), .HALF_CYC(4),
                      .SYNC_STAGES(2), .EDGE_MODE(1'b1), .RETRIG(1'b0)) dut_d (
    .clk(clk), .rst_n(rst_n), .SnsDisable(sns), .SnsMask(mask), .ForceClear(fc),
    .Enable(en_d), .Pause(pause_d), .Cause(cause_d), .Done(done_d));

  typedef struct {
    logic [1:0] sns;
    logic [1:0] mask;
    logic       fc;
    logic       en;
    logic       pause;
    logic [1:0] cause;
    logic       done;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs just after an edge, then sample just after the next edge.
  task automatic step(input logic [1:0] s, input logic [1:0] m, input logic f);
    sns  = s;
    mask = m;
    fc   = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] s);
    rst_n = 1'b0;
    sns   = s;
    mask  = 2'b00;
    fc    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_a, p_b, lo_a, lo_b, dn_a, dn_b, cnt, rise;

    // sns, mask, fc  ->  en, pause, cause, done (outputs after that cycle's edge)
    vecs[0]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[1]  = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[2]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[3]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[4]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[5]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[6]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[7]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[8]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[9]  = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[10] = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[11] = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
    vecs[12] = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[13] = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0};
    vecs[14] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0};
    vecs[15] = '{2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[16] = '{2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[17] = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[18] = '{2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[19] = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};

    // Basic pause, cause replacement, ForceClear with dropped trigger, masking.
    do_reset(2'b00);
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].sns, vecs[i].mask, vecs[i].fc);
      check($sformatf("vec%0d.enable", i), 32'(en_a),    32'(vecs[i].en));
      check($sformatf("vec%0d.pause",  i), 32'(pause_a), 32'(vecs[i].pause));
      check($sformatf("vec%0d.cause",  i), 32'(cause_a), 32'(vecs[i].cause));
      check($sformatf("vec%0d.done",   i), 32'(done_a),  32'(vecs[i].done));
    end

    // Second trigger on ch1 in the third CREEP cycle: a ignores it for timing, b restarts.
    do_reset(2'b00);
    p_a = 0; p_b = 0; lo_a = 0; lo_b = 0; dn_a = 0; dn_b = 0;
    for (int i = 0; i < 25; i++) begin
      step((i == 0) ? 2'b01 : ((i == 7) ? 2'b10 : 2'b00), 2'b00, 1'b0);
      if (pause_a) p_a++;
      if (pause_b) p_b++;
      if (!en_a) lo_a++;
      if (!en_b) lo_b++;
      if (done_a) dn_a++;
      if (done_b) dn_b++;
    end
    check("noretrig.pause_cycles",  32'(p_a),  32'd10);
    check("noretrig.enable_low",    32'(lo_a), 32'd4);
    check("noretrig.done_pulses",   32'(dn_a), 32'd1);
    check("noretrig.cause",         32'(cause_a), 32'h3);
    check("retrig.pause_cycles",    32'(p_b),  32'd17);
    check("retrig.enable_low",      32'(lo_b), 32'd8);
    check("retrig.done_pulses",     32'(dn_b), 32'd1);
    check("retrig.cause",           32'(cause_b), 32'h3);

    // Level mode with ch0 held: pause, one IDLE cycle with Done, pause again.
    do_reset(2'b00);
    cnt = 0;
    for (int i = 0; i < 21; i++) begin
      step(2'b01, 2'b00, 1'b0);
      if (pause_c) cnt++;
      if (i == 10) begin
        check("level.gap_pause", 32'(pause_c), 32'd0);
        check("level.gap_done",  32'(done_c),  32'd1);
      end
      if (i == 11) check("level.repause", 32'(pause_c), 32'd1);
    end
    check("level.pause_cycles", 32'(cnt), 32'd20);

    // Level mode, held input but masked: never pauses.
    do_reset(2'b00);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(2'b01, 2'b01, 1'b0);
      if (pause_c) cnt++;
    end
    check("level.masked_pause", 32'(cnt), 32'd0);

    // Asynchronous reset in the middle of CREEP.
    do_reset(2'b00);
    step(2'b01, 2'b00, 1'b0);
    for (int i = 0; i < 6; i++) step(2'b00, 2'b00, 1'b0);
    check("creep.enable", 32'(en_a),    32'd1);
    check("creep.pause",  32'(pause_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.enable", 32'(en_a),    32'd1);
    check("async_rst.pause",  32'(pause_a), 32'd0);
    check("async_rst.cause",  32'(cause_a), 32'd0);
    check("async_rst.done",   32'(done_a),  32'd0);

    // Input already high when reset is released counts as a rising edge.
    do_reset(2'b01);
    step(2'b01, 2'b00, 1'b0);
    check("rst_release_edge.pause", 32'(pause_a), 32'd1);
    check("rst_release_edge.cause", 32'(cause_a), 32'd1);

    // Two-stage synchroniser: Pause rises on the third edge after the input edge.
    do_reset(2'b00);
    rise = -1;
    for (int i = 0; i < 10; i++) begin
      step(2'b01, 2'b00, 1'b0);
      if (pause_d && rise < 0) rise = i + 1;
    end
    check("sync2.latency", 32'(rise), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
